// File: rtl/processador_multiciclo.sv
// Multi-cycle RV32I-subset core with a single shared req/ready memory port.
// A FETCH/DECODE/EXEC/MEM/WB/HALT state machine sequences each instruction over the one port.
module processador_multiciclo #(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic             erro,
  output logic [XLEN-1:0]  pc_atual,
  output logic [CNT_W-1:0] instr_retiradas
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic [31:0]       ir_q, ir_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              halted_q, halted_d, erro_q, erro_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NUM_REGS];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic       is_r, is_i, is_lw, is_sw, is_br, is_ebreak, regs_ok, legal;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_sel, opnd_b, alu_res;
  logic [XLEN-1:0] eaddr, br_target, pc_plus4, br_next;
  logic       taken;
  logic       rf_we;

  assign opcode = ir_q[6:0];
  assign rd_f   = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1_f  = ir_q[19:15];
  assign rs2_f  = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // Instruction classification stays valid from DECODE through WB because ir_q is held.
  always_comb begin
    is_r = (opcode == 7'b0110011) &&
           ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 ||
                                      funct3 == 3'b100 || funct3 == 3'b010)) ||
            (funct7 == 7'b0100000 && funct3 == 3'b000));
    is_i = (opcode == 7'b0010011) &&
           (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b010);
    is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_br     = (opcode == 7'b1100011) && (funct3 == 3'b000 || funct3 == 3'b001);
    is_ebreak = (ir_q == 32'h0010_0073);
    regs_ok = !((is_r || is_i || is_lw) && int'(rd_f) >= NUM_REGS) &&
              !((is_r || is_i || is_lw || is_sw || is_br) && int'(rs1_f) >= NUM_REGS) &&
              !((is_r || is_sw || is_br) && int'(rs2_f) >= NUM_REGS);
    legal = (is_r || is_i || is_lw || is_sw || is_br) && regs_ok;
  end

  assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_sel = is_sw ? imm_s : (is_br ? imm_b : imm_i);

  assign opnd_b    = is_r ? b_q : imm_q;
  assign eaddr     = a_q + imm_q;
  assign br_target = pc_q + imm_q;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign taken     = (a_q == b_q) ^ funct3[0];
  assign br_next   = taken ? br_target : pc_plus4;

  always_comb begin
    alu_res = a_q + opnd_b;
    case (funct3)
      3'b000:  alu_res = (is_r && funct7[5]) ? (a_q - opnd_b) : (a_q + opnd_b);
      3'b111:  alu_res = a_q & opnd_b;
      3'b110:  alu_res = a_q | opnd_b;
      3'b100:  alu_res = a_q ^ opnd_b;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(opnd_b))};
      default: alu_res = a_q + opnd_b;
    endcase
  end

  // Every path back to FETCH launches the next fetch request directly, saving a cycle per instruction.
  always_comb begin
    state_d = state_q;  pc_d = pc_q;  ir_d = ir_q;
    a_d = a_q;  b_d = b_q;  imm_d = imm_q;  res_d = res_q;
    mem_req_d = mem_req_q;  mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;
    halted_d = halted_q;  erro_d = erro_q;  cnt_d = cnt_q;
    rf_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;  mem_we_d = 1'b0;  mem_addr_d = pc_q;
        end else if (mem_ready) begin
          ir_d = mem_rdata[31:0];  mem_req_d = 1'b0;  state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = regs_q[rs1_f[IDX_W-1:0]];
        b_d   = regs_q[rs2_f[IDX_W-1:0]];
        imm_d = imm_sel;
        if (is_ebreak) begin
          halted_d = 1'b1;  state_d = S_HALT;
        end else if (!legal) begin
          halted_d = 1'b1;  erro_d = 1'b1;  state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          if (taken && br_target[1:0] != 2'b00) begin
            halted_d = 1'b1;  erro_d = 1'b1;  state_d = S_HALT;
          end else begin
            pc_d = br_next;  cnt_d = cnt_q + CNT_W'(1);
            mem_req_d = 1'b1;  mem_we_d = 1'b0;  mem_addr_d = br_next;  state_d = S_FETCH;
          end
        end else if (is_lw || is_sw) begin
          if (eaddr[1:0] != 2'b00) begin
            halted_d = 1'b1;  erro_d = 1'b1;  state_d = S_HALT;
          end else begin
            mem_req_d = 1'b1;  mem_we_d = is_sw;  mem_addr_d = eaddr;
            if (is_sw) mem_wdata_d = b_q;
            state_d = S_MEM;
          end
        end else begin
          res_d = alu_res;  state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            pc_d = pc_plus4;  cnt_d = cnt_q + CNT_W'(1);
            mem_req_d = 1'b1;  mem_we_d = 1'b0;  mem_addr_d = pc_plus4;  state_d = S_FETCH;
          end else begin
            res_d = mem_rdata;  mem_req_d = 1'b0;  mem_we_d = 1'b0;  state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = (rd_f != 5'd0);
        pc_d = pc_plus4;  cnt_d = cnt_q + CNT_W'(1);
        mem_req_d = 1'b1;  mem_we_d = 1'b0;  mem_addr_d = pc_plus4;  state_d = S_FETCH;
      end
      S_HALT:  mem_req_d = 1'b0;
      default: begin
        halted_d = 1'b1;  erro_d = 1'b1;  mem_req_d = 1'b0;  state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;  pc_q <= RESET_PC;  ir_q <= '0;
      a_q <= '0;  b_q <= '0;  imm_q <= '0;  res_q <= '0;
      mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;
      halted_q <= 1'b0;  erro_q <= 1'b0;  cnt_q <= '0;
    end else begin
      state_q <= state_d;  pc_q <= pc_d;  ir_q <= ir_d;
      a_q <= a_d;  b_q <= b_d;  imm_q <= imm_d;  res_q <= res_d;
      mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
      halted_q <= halted_d;  erro_q <= erro_d;  cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd_f[IDX_W-1:0]] <= res_q;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign halted          = halted_q;
  assign erro            = erro_q;
  assign pc_atual        = pc_q;
  assign instr_retiradas = cnt_q;

endmodule
